mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_map_pkg.sv | 21 ++
 rtl/console_fifo.sv | 43 ++++
 rtl/mem_responder.sv | 75 +++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared word-address map and STATUS layout for mem_responder and CPU test programs
package mem_map_pkg;
    localparam logic [15:0] ADDR_LED     = 16'h7FF0;
    localparam logic [15:0] ADDR_TIMER   = 16'h7FF1;
    localparam logic [15:0] ADDR_CONSOLE = 16'h7FF2;
    localparam logic [15:0] ADDR_STATUS  = 16'h7FF3;
    localparam logic [15:0] ADDR_DROPS   = 16'h7FF4;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_COUNT_LSB = 4;

    function automatic logic [15:0] status_word(input logic full, input logic empty, input logic [3:0] count);
        logic [15:0] s;
        s = 16'h0000;
        s[ST_FULL] = full;
        s[ST_EMPTY] = empty;
        s[ST_COUNT_LSB +: 4] = count;
        return s;
    endfunction
endpackage

// File: rtl/console_fifo.sv
// console_fifo: console word queue; push/pop are pre-qualified by the caller
// Ports: clk, rst_n (async active-low), push/wdata (enqueue), pop (dequeue),
//        rdata (head word, 0 when empty), full, empty, count (occupancy)
module console_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;

    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    // Head is forced to zero when empty so it reads 0 through reset
    assign rdata = empty ? '0 : mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: CPU-facing RAM plus LED, timer, console FIFO, status and drop-counter registers
// Ports: clk, rst_n (async active-low), address/wdata/wr (CPU bus in), rdata (registered read),
//        leds (LED register), con_data/con_valid/con_ready (console stream out)
module mem_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        wr,
    output logic [15:0] rdata,
    output logic [7:0]  leds,
    output logic [15:0] con_data,
    output logic        con_valid,
    input  logic        con_ready
);
    import mem_map_pkg::*;

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   ram [RAM_WORDS];
    logic [15:0]   timer, drops, status, rd_val;
    logic [CW-1:0] count;
    logic          ram_hit, push_req, push, pop, full, empty, drop;

    assign ram_hit   = 32'(address) < RAM_WORDS;
    assign con_valid = !empty;
    assign pop       = con_valid && con_ready;
    assign push_req  = wr && address == ADDR_CONSOLE;
    // A pop on the same edge frees the slot a full FIFO needs
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign status    = status_word(full, empty, 4'(count));

    // Same-edge writes are forwarded so the read returns the committed value
    assign rd_val = ram_hit                ? (wr ? wdata : ram[address[AW-1:0]]) :
                    address == ADDR_LED    ? {8'h00, wr ? wdata[7:0] : leds} :
                    address == ADDR_TIMER  ? (wr ? 16'h0000 : timer) :
                    address == ADDR_STATUS ? status :
                    address == ADDR_DROPS  ? (wr ? 16'h0000 : drops) : 16'h0000;

    console_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (con_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 16'h0000;
            leds  <= 8'h00;
            timer <= 16'h0000;
            drops <= 16'h0000;
        end else begin
            rdata <= rd_val;
            if (wr && address == ADDR_LED) leds <= wdata[7:0];
            timer <= (wr && address == ADDR_TIMER) ? 16'h0000 : timer + 16'h0001;
            if (wr && address == ADDR_DROPS) drops <= 16'h0000;
            else if (drop && drops != 16'hFFFF) drops <= drops + 16'h0001;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && ram_hit) ram[address[AW-1:0]] <= wdata;
    end
endmodule
